// File: rtl/cache_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// cache_port_arbiter_if
// Bundles the two requester handshakes, the cache-side op port and the status
// outputs of cache_port_arbiter.
//   slave  : arbiter side (takes requests, drives ready / cache port / status)
//   master : requester/environment side (drives requests, observes the rest)
// Signals:
//   req0_valid/req1_valid  requester has an op pending
//   req0_addr/req1_addr    48-bit request address
//   req0_op/req1_op        8-bit op code (8'h52 R, 8'h57 W)
//   req0_ready/req1_ready  request accepted this cycle
//   cache_addr/cache_op    op held on the cache port (8'h00 = NOP)
//   busy, err, last_grant  status
//   grant0_cnt/grant1_cnt  accepted-op counters (zero unless stats enabled)
// ----------------------------------------------------------------------------
interface cache_port_arbiter_if;
  logic        req0_valid;
  logic        req1_valid;
  logic [47:0] req0_addr;
  logic [47:0] req1_addr;
  logic [7:0]  req0_op;
  logic [7:0]  req1_op;
  logic        req0_ready;
  logic        req1_ready;
  logic [47:0] cache_addr;
  logic [7:0]  cache_op;
  logic        busy;
  logic        err;
  logic        last_grant;
  logic [11:0] grant0_cnt;
  logic [11:0] grant1_cnt;

  modport slave (
    input  req0_valid, req1_valid, req0_addr, req1_addr, req0_op, req1_op,
    output req0_ready, req1_ready, cache_addr, cache_op, busy, err,
           last_grant, grant0_cnt, grant1_cnt
  );

  modport master (
    output req0_valid, req1_valid, req0_addr, req1_addr, req0_op, req1_op,
    input  req0_ready, req1_ready, cache_addr, cache_op, busy, err,
           last_grant, grant0_cnt, grant1_cnt
  );
endinterface

// File: rtl/cache_port_arbiter.sv
// ----------------------------------------------------------------------------
// cache_port_arbiter
// Round-robin arbiter between two requesters for a single cache port. An
// accepted legal op (R = 8'h52, W = 8'h57) is registered and held on the cache
// port for HOLD_CYCLES cycles; the next op may follow back-to-back. An
// accepted illegal op is dropped and flagged with a one-cycle err pulse.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    cache_port_arbiter_if.slave (requests, ready, cache port, status)
// Parameter:
//   HOLD_CYCLES  cycles each op is held on the cache port (1..15)
// Optional feature:
//   CACHE_ARB_STATS_EN  when defined, grant0_cnt/grant1_cnt count legal
//                       accepted ops per requester, saturating at 12'hFFF;
//                       otherwise both read 0.
// ----------------------------------------------------------------------------
module cache_port_arbiter #(
  parameter int unsigned HOLD_CYCLES = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  cache_port_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);
  localparam logic [7:0] OP_R      = 8'h52;
  localparam logic [7:0] OP_W      = 8'h57;
  localparam logic [7:0] OP_NOP    = 8'h00;

  function automatic logic op_legal(input logic [7:0] op);
    return (op == OP_R) || (op == OP_W);
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  hold_cnt_q, hold_cnt_d;
  logic [47:0] cache_addr_q, cache_addr_d;
  logic [7:0]  cache_op_q, cache_op_d;
  logic        err_q, err_d;
  logic        last_grant_q, last_grant_d;

  logic        can_accept_s;
  logic        sel_s;
  logic        sel_valid_s;
  logic [47:0] sel_addr_s;
  logic [7:0]  sel_op_s;
  logic        sel_legal_s;
  logic        hs_s;

  // Grant selection: round-robin when both are pending, otherwise the pending one.
  always_comb begin
    can_accept_s = 1'b0;
    sel_s        = ~last_grant_q;
    sel_valid_s  = 1'b0;
    sel_addr_s   = 48'h0;
    sel_op_s     = OP_NOP;
    if (state_q == IDLE) begin
      can_accept_s = 1'b1;
    end else if (hold_cnt_q == 4'd0) begin
      can_accept_s = 1'b1;
    end else begin
      can_accept_s = 1'b0;
    end
    if (bus.req0_valid && bus.req1_valid) begin
      sel_s = ~last_grant_q;
    end else if (bus.req1_valid) begin
      sel_s = 1'b1;
    end else if (bus.req0_valid) begin
      sel_s = 1'b0;
    end else begin
      sel_s = ~last_grant_q;
    end
    if (sel_s) begin
      sel_valid_s = bus.req1_valid;
      sel_addr_s  = bus.req1_addr;
      sel_op_s    = bus.req1_op;
    end else begin
      sel_valid_s = bus.req0_valid;
      sel_addr_s  = bus.req0_addr;
      sel_op_s    = bus.req0_op;
    end
  end

  assign sel_legal_s    = op_legal(sel_op_s);
  // ready is gated by reset directly so it is low for the whole reset period.
  assign bus.req0_ready = reset & can_accept_s & ~sel_s;
  assign bus.req1_ready = reset & can_accept_s & sel_s;
  assign hs_s           = reset & can_accept_s & sel_valid_s;

  // Next-state logic: hold/decrement/return-to-idle, then handshake overrides.
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    cache_addr_d = cache_addr_q;
    cache_op_d   = cache_op_q;
    err_d        = 1'b0;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        hold_cnt_d   = 4'd0;
        cache_addr_d = 48'h0;
        cache_op_d   = OP_NOP;
      end
      HOLD: begin
        if (hold_cnt_q != 4'd0) begin
          hold_cnt_d = hold_cnt_q - 4'd1;
        end else begin
          state_d      = IDLE;
          cache_addr_d = 48'h0;
          cache_op_d   = OP_NOP;
        end
      end
      default: begin
        state_d      = IDLE;
        hold_cnt_d   = 4'd0;
        cache_addr_d = 48'h0;
        cache_op_d   = OP_NOP;
      end
    endcase
    // A handshake can only happen in IDLE or on the last HOLD cycle, so it
    // safely replaces whatever the case above decided.
    if (hs_s) begin
      last_grant_d = sel_s;
      if (sel_legal_s) begin
        state_d      = HOLD;
        hold_cnt_d   = HOLD_LOAD;
        cache_addr_d = sel_addr_s;
        cache_op_d   = sel_op_s;
      end else begin
        state_d      = IDLE;
        hold_cnt_d   = 4'd0;
        cache_addr_d = 48'h0;
        cache_op_d   = OP_NOP;
        err_d        = 1'b1;
      end
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // State and cache-port registers; last_grant resets to 1 so requester 0 wins first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      hold_cnt_q   <= 4'd0;
      cache_addr_q <= 48'h0;
      cache_op_q   <= OP_NOP;
      err_q        <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      cache_addr_q <= cache_addr_d;
      cache_op_q   <= cache_op_d;
      err_q        <= err_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.cache_addr = cache_addr_q;
  assign bus.cache_op   = cache_op_q;
  assign bus.busy       = (state_q == HOLD);
  assign bus.err        = err_q;
  assign bus.last_grant = last_grant_q;

`ifdef CACHE_ARB_STATS_EN
  logic [11:0] grant0_cnt_q, grant0_cnt_d;
  logic [11:0] grant1_cnt_q, grant1_cnt_d;

  // Saturating per-requester counters of legal accepted ops.
  always_comb begin
    grant0_cnt_d = grant0_cnt_q;
    grant1_cnt_d = grant1_cnt_q;
    if (hs_s && sel_legal_s && !sel_s && (grant0_cnt_q != 12'hFFF)) begin
      grant0_cnt_d = grant0_cnt_q + 12'd1;
    end else begin
      grant0_cnt_d = grant0_cnt_q;
    end
    if (hs_s && sel_legal_s && sel_s && (grant1_cnt_q != 12'hFFF)) begin
      grant1_cnt_d = grant1_cnt_q + 12'd1;
    end else begin
      grant1_cnt_d = grant1_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant0_cnt_q <= 12'h000;
      grant1_cnt_q <= 12'h000;
    end else begin
      grant0_cnt_q <= grant0_cnt_d;
      grant1_cnt_q <= grant1_cnt_d;
    end
  end

  assign bus.grant0_cnt = grant0_cnt_q;
  assign bus.grant1_cnt = grant1_cnt_q;
`else
  assign bus.grant0_cnt = 12'h000;
  assign bus.grant1_cnt = 12'h000;
`endif

endmodule

// File: tb/tb_cache_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cache_port_arbiter
// Directed stimulus pushes the expected grant sequence (requester, addr, op,
// legality) into a queue; a monitor sampling on the falling edge pops an
// entry on every handshake and checks the cache port, hold length, err pulse,
// last_grant and reset behaviour.
// ----------------------------------------------------------------------------
module tb_cache_port_arbiter;
  localparam int         HOLD   = 5;
  localparam logic [7:0] OP_R   = 8'h52;
  localparam logic [7:0] OP_W   = 8'h57;
  localparam logic [7:0] OP_NOP = 8'h00;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  cache_port_arbiter_if bus();

  cache_port_arbiter #(.HOLD_CYCLES(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        idx;
    logic [47:0] addr;
    logic [7:0]  op;
    logic        legal;
  } txn_t;

  txn_t exp_q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   exp_cnt0 = 0;
  int   exp_cnt1 = 0;

  function void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic pend = 1'b0;
  logic act  = 1'b0;
  txn_t pend_t;
  txn_t act_t;
  txn_t pop_t;
  int   act_cycles = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("rst_cache_op", 64'(bus.cache_op), 64'(OP_NOP));
        chk("rst_cache_addr", 64'(bus.cache_addr), 64'h0);
        chk("rst_busy", 64'(bus.busy), 64'h0);
        chk("rst_err", 64'(bus.err), 64'h0);
        chk("rst_last_grant", 64'(bus.last_grant), 64'h1);
        chk("rst_ready", 64'({bus.req1_ready, bus.req0_ready}), 64'h0);
        chk("rst_cnts", 64'({bus.grant1_cnt, bus.grant0_cnt}), 64'h0);
        pend = 1'b0;
        act  = 1'b0;
      end else begin
        if (pend) begin
          if (pend_t.legal) begin
            chk("issue_op", 64'(bus.cache_op), 64'(pend_t.op));
            chk("issue_addr", 64'(bus.cache_addr), 64'(pend_t.addr));
            chk("issue_busy", 64'(bus.busy), 64'h1);
            chk("issue_err", 64'(bus.err), 64'h0);
            act        = 1'b1;
            act_t      = pend_t;
            act_cycles = 1;
          end else begin
            chk("illegal_err", 64'(bus.err), 64'h1);
            chk("illegal_op", 64'(bus.cache_op), 64'(OP_NOP));
            chk("illegal_busy", 64'(bus.busy), 64'h0);
            act = 1'b0;
          end
          chk("last_grant", 64'(bus.last_grant), 64'(pend_t.idx));
          pend = 1'b0;
        end else if (act) begin
          if (act_cycles < HOLD) begin
            chk("hold_op", 64'(bus.cache_op), 64'(act_t.op));
            chk("hold_addr", 64'(bus.cache_addr), 64'(act_t.addr));
            chk("hold_busy", 64'(bus.busy), 64'h1);
            act_cycles++;
          end else begin
            chk("end_op", 64'(bus.cache_op), 64'(OP_NOP));
            chk("end_addr", 64'(bus.cache_addr), 64'h0);
            chk("end_busy", 64'(bus.busy), 64'h0);
            act = 1'b0;
          end
        end else begin
          chk("idle_op", 64'(bus.cache_op), 64'(OP_NOP));
          chk("idle_busy", 64'(bus.busy), 64'h0);
          chk("idle_err", 64'(bus.err), 64'h0);
        end
        chk("ready_onehot", 64'(bus.req0_ready & bus.req1_ready), 64'h0);
        if (act && (act_cycles < HOLD)) begin
          chk("ready_in_hold", 64'(bus.req0_ready | bus.req1_ready), 64'h0);
        end
        if ((bus.req0_ready && bus.req0_valid) || (bus.req1_ready && bus.req1_valid)) begin
          if (act) begin
            chk("back_to_back_at", 64'(act_cycles), 64'(HOLD));
          end
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_grant: actual handshake req%0d required none", bus.req1_ready);
          end else begin
            pop_t = exp_q.pop_front();
            chk("grant_idx", 64'(bus.req1_ready), 64'(pop_t.idx));
            pend   = 1'b1;
            pend_t = pop_t;
          end
          act = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input logic idx, input logic v, input logic [47:0] a, input logic [7:0] o);
    if (idx) begin
      bus.req1_valid = v;
      bus.req1_addr  = a;
      bus.req1_op    = o;
    end else begin
      bus.req0_valid = v;
      bus.req0_addr  = a;
      bus.req0_op    = o;
    end
  endtask

  task automatic expect_txn(input logic idx, input logic [47:0] a, input logic [7:0] o, input logic legal);
    txn_t t;
    t.idx   = idx;
    t.addr  = a;
    t.op    = o;
    t.legal = legal;
    exp_q.push_back(t);
  endtask

  // Present one op, wait (bounded) for the handshake, then scramble the inputs.
  task automatic drive(input logic idx, input logic [47:0] a, input logic [7:0] o, input logic legal);
    bit done = 1'b0;
    set_req(idx, 1'b1, a, o);
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (idx ? bus.req1_ready : bus.req0_ready) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL handshake_timeout: req%0d actual no ready in 200 cycles, required ready", idx);
    end else if (legal) begin
      if (idx) exp_cnt1 = (exp_cnt1 < 4095) ? exp_cnt1 + 1 : 4095;
      else     exp_cnt0 = (exp_cnt0 < 4095) ? exp_cnt0 + 1 : 4095;
    end
    @(posedge clk);
    #1;
    set_req(idx, 1'b0, ~a, 8'hFF);
  endtask

  task automatic settle();
    repeat (HOLD + 3) @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    set_req(1'b1, 1'b0, 48'h0, OP_NOP);
    set_req(1'b0, 1'b1, 48'h0000_0000_1234, OP_W);  // ready must stay low in reset
    reset = 1'b0;
    repeat (3) @(negedge clk);
    set_req(1'b0, 1'b0, 48'h0, OP_NOP);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Single write from requester 0.
    expect_txn(1'b0, 48'h7fff493822b8, OP_W, 1'b1);
    drive(1'b0, 48'h7fff493822b8, OP_W, 1'b1);
    settle();

    // Reset pulse so both-valid arbitration starts from requester 0.
    reset = 1'b0;
    exp_cnt0 = 0;
    exp_cnt1 = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Both valid continuously: 0,1,0,1 back-to-back.
    expect_txn(1'b0, 48'h0000_1111_2222, OP_W, 1'b1);
    expect_txn(1'b1, 48'h8000_0000_0001, OP_R, 1'b1);
    expect_txn(1'b0, 48'hffff_ffff_fffe, OP_R, 1'b1);
    expect_txn(1'b1, 48'h0123_4567_89ab, OP_W, 1'b1);
    fork
      begin
        drive(1'b0, 48'h0000_1111_2222, OP_W, 1'b1);
        drive(1'b0, 48'hffff_ffff_fffe, OP_R, 1'b1);
      end
      begin
        drive(1'b1, 48'h8000_0000_0001, OP_R, 1'b1);
        drive(1'b1, 48'h0123_4567_89ab, OP_W, 1'b1);
      end
    join
    settle();

    // Illegal op from requester 1.
    expect_txn(1'b1, 48'h0000_0000_0abc, 8'h41, 1'b0);
    drive(1'b1, 48'h0000_0000_0abc, 8'h41, 1'b0);
    settle();

    // Reset caught mid-HOLD: outputs drop at once, op is not reissued.
    expect_txn(1'b0, 48'h0000_dead_0005, OP_W, 1'b1);
    drive(1'b0, 48'h0000_dead_0005, OP_W, 1'b1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    exp_cnt0 = 0;
    exp_cnt1 = 0;
    #1;
    chk("async_rst_op", 64'(bus.cache_op), 64'(OP_NOP));
    chk("async_rst_busy", 64'(bus.busy), 64'h0);
    chk("async_rst_addr", 64'(bus.cache_addr), 64'h0);
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    expect_txn(1'b0, 48'h0000_0000_0e0e, OP_R, 1'b1);
    expect_txn(1'b1, 48'h0000_0000_0f0f, OP_W, 1'b1);
    fork
      drive(1'b0, 48'h0000_0000_0e0e, OP_R, 1'b1);
      drive(1'b1, 48'h0000_0000_0f0f, OP_W, 1'b1);
    join
    settle();

`ifdef CACHE_ARB_STATS_EN
    for (int i = 0; i < 4096; i++) begin
      expect_txn(1'b0, 48'(i), OP_W, 1'b1);
      drive(1'b0, 48'(i), OP_W, 1'b1);
    end
    settle();
    chk("grant0_cnt_sat", 64'(bus.grant0_cnt), 64'(exp_cnt0));
    chk("grant0_cnt_fff", 64'(bus.grant0_cnt), 64'h0FFF);
    chk("grant1_cnt", 64'(bus.grant1_cnt), 64'(exp_cnt1));
`else
    chk("grant0_cnt_off", 64'(bus.grant0_cnt), 64'h0);
    chk("grant1_cnt_off", 64'(bus.grant1_cnt), 64'h0);
`endif

    chk("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_port_arbiter.md
CACHE_PORT_ARBITER -- requirements
Module: cache_port_arbiter

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 5: cycles each issued op is held on the cache port (legal range 1..15).
REQ-002 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1: asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have ports req0_valid / req1_valid  input  1 each: requester has an op pending.
REQ-005 SHALL have ports req0_addr / req1_addr  input  48 each: request address.
REQ-006 SHALL have ports req0_op / req1_op  input  8 each: op code, 8'h52 = R, 8'h57 = W.
REQ-007 SHALL have ports req0_ready / req1_ready  output  1 each: request accepted this cycle.
REQ-008 SHALL have port cache_addr  output  48: address driven to the cache.
REQ-009 SHALL have port cache_op  output  8: op driven to the cache; 8'h00 = NOP.
REQ-010 SHALL have port busy  output  1: an op is being held on the cache port.
REQ-011 SHALL have port err  output  1: one-cycle pulse when an illegal op is accepted.
REQ-012 SHALL have port last_grant  output  1: index of the most recently accepted requester.
REQ-013 SHALL have ports grant0_cnt / grant1_cnt  output  12 each: per-requester accepted-op counters.

Function
REQ-014 SHALL use a two-state FSM: IDLE and HOLD, with a 4-bit hold counter.
REQ-015 SHALL compute ready combinationally: asserted in IDLE, or in HOLD when hold counter == 0; otherwise 0.
REQ-016 SHALL assert ready to at most one requester per cycle.
REQ-017 SHALL grant round-robin: if both are valid, grant the requester not equal to last_grant; if one is valid, grant it.
REQ-018 SHALL complete a handshake on a rising edge when valid and ready are both 1 for the same requester.
REQ-019 SHALL, on a handshake with a legal op (8'h52 or 8'h57): register addr/op onto cache_addr/cache_op, enter HOLD, and load hold counter = HOLD_CYCLES-1.
REQ-020 SHALL hold cache_addr/cache_op stable for exactly HOLD_CYCLES cycles per op.
REQ-021 SHALL decrement the hold counter each HOLD cycle.
REQ-022 SHALL, at HOLD with counter == 0 and a legal handshake, start the next op immediately (back-to-back, no NOP gap).
REQ-023 SHALL, at HOLD with counter == 0 and no handshake, return to IDLE and drive cache_op = 8'h00 and cache_addr = 0.
REQ-024 SHALL, on a handshake with an illegal op: pulse err for the following cycle, not issue the op, and enter IDLE with cache_op = 8'h00.
REQ-025 SHALL update last_grant on every handshake, legal or illegal.
REQ-026 SHALL drive busy = 1 exactly while in HOLD.
REQ-027 SHALL ignore changes to a requester's inputs once it has been accepted; the registered values are used.

Reset
REQ-028 SHALL, while reset = 0, asynchronously force: IDLE, hold counter 0, cache_addr 0, cache_op 8'h00, busy 0, err 0, last_grant 1 (so requester 0 wins first), counters 0.
REQ-029 SHALL abandon an op caught in HOLD by reset; it SHALL not be reissued after release.
REQ-030 SHALL keep both ready outputs at 0 while reset = 0.

Configuration
REQ-031 SHALL, with macro CACHE_ARB_STATS_EN defined, increment grant0_cnt/grant1_cnt on each legal handshake of that requester, saturating at 12'hFFF.
REQ-032 SHALL, without CACHE_ARB_STATS_EN, tie grant0_cnt/grant1_cnt to 0 and include no counter logic.

Verification
REQ-033 SHALL cover: after reset, req0 only, addr 48'h7fff493822b8, op 8'h57 -> cache_op = 8'h57 for exactly 5 cycles, then 8'h00; busy high for the same 5 cycles.
REQ-034 SHALL cover: both valid continuously, HOLD_CYCLES = 5 -> grants alternate 0,1,0,1 with no NOP gap; each op lasts 5 cycles.
REQ-035 SHALL cover: req1 op 8'h41 -> req1_ready pulses, err pulses once, cache_op stays 8'h00, last_grant = 1.
REQ-036 SHALL cover: reset asserted mid-HOLD at cycle 2 -> cache_op = 8'h00 and busy = 0 immediately, without waiting for a clock edge; after release, requester 0 is granted first.
REQ-037 SHALL cover, with CACHE_ARB_STATS_EN: 4096 legal req0 ops -> grant0_cnt saturates at 12'hFFF; without the macro, both counters read 0.
